// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter: N-to-1 round-robin arbiter onto one MMU port.
// An in-order tag FIFO routes each MMU response back to its issuer.

module mmu_port_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int WORD_WIDTH      = 32,
   parameter int OP_WIDTH        = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_PORTS-1:0]           req_valid_in,
   output logic [NUM_PORTS-1:0]           req_ready_out,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] req_address_in,
   input  logic [NUM_PORTS*OP_WIDTH-1:0]   req_operation_in,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] req_data_in,
   output logic [NUM_PORTS-1:0]           resp_valid_out,
   input  logic [NUM_PORTS-1:0]           resp_ready_in,
   output logic [WORD_WIDTH-1:0]          resp_data_out,
   input  logic                           mmu_request_ready_in,
   output logic                           mmu_request_valid_out,
   output logic [WORD_WIDTH-1:0]          mmu_request_address_out,
   output logic [OP_WIDTH-1:0]            mmu_request_operation_out,
   output logic [WORD_WIDTH-1:0]          mmu_request_data_out,
   output logic                           mmu_response_ready_out,
   input  logic                           mmu_response_valid_in,
   input  logic [WORD_WIDTH-1:0]          mmu_response_data_in
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   typedef enum logic {
      ST_FREE,
      ST_LOCKED
   } lock_e;

   lock_e          state_q, state_d;
   logic [IW-1:0]  last_grant_q, last_grant_d;
   logic [IW-1:0]  locked_port_q, locked_port_d;
   logic [IW-1:0]  grant;
   logic [IW-1:0]  head;
   logic [IW-1:0]  tag_q [MAX_OUTSTANDING];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;

   assign full  = (count_q == CW'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);
   assign head  = tag_q[rd_ptr_q];
   assign push  = mmu_request_valid_out && mmu_request_ready_in;
   assign pop   = mmu_response_valid_in && mmu_response_ready_out;

   // Round-robin scan from last_grant+1; a stalled request holds the grant
   always_comb begin
      grant = last_grant_q;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (req_valid_in[IW'((int'(last_grant_q) + k) % NUM_PORTS)]) begin
            grant = IW'((int'(last_grant_q) + k) % NUM_PORTS);
         end
      end
      if (state_q == ST_LOCKED) begin
         grant = locked_port_q;
      end
   end

   // Request path: granted port passes straight through to the MMU
   always_comb begin
      mmu_request_valid_out     = 1'b0;
      req_ready_out             = '0;
      mmu_request_address_out   = '0;
      mmu_request_operation_out = '0;
      mmu_request_data_out      = '0;
      if (!rst_in) begin
         mmu_request_valid_out = req_valid_in[grant] && !full;
         req_ready_out[grant]  = mmu_request_ready_in && !full;
         mmu_request_address_out =
            req_address_in[int'(grant)*WORD_WIDTH +: WORD_WIDTH];
         mmu_request_operation_out =
            req_operation_in[int'(grant)*OP_WIDTH +: OP_WIDTH];
         mmu_request_data_out =
            req_data_in[int'(grant)*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   // Response path: FIFO head selects which port sees the response
   always_comb begin
      resp_valid_out         = '0;
      mmu_response_ready_out = 1'b0;
      resp_data_out          = '0;
      if (!rst_in) begin
         resp_data_out = mmu_response_data_in;
         if (!empty) begin
            resp_valid_out[head]   = mmu_response_valid_in;
            mmu_response_ready_out = resp_ready_in[head];
         end
      end
   end

   // Lock FSM and round-robin pointer next-state
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      locked_port_d = locked_port_q;
      if (push) begin
         state_d      = ST_FREE;
         last_grant_d = grant;
      end else if (mmu_request_valid_out) begin
         state_d       = ST_LOCKED;
         locked_port_d = grant;
      end
   end

   // Tag FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // State registers; reset makes port 0 the first winner
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= ST_FREE;
         last_grant_q  <= IW'(NUM_PORTS - 1);
         locked_port_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         locked_port_q <= locked_port_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Tag storage records the issuing port of each accepted request
   always_ff @(posedge clk_in) begin
      if (push) begin
         tag_q[wr_ptr_q] <= grant;
      end
   end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// tb_mmu_port_arbiter: directed and random checks of mmu_port_arbiter
// against a queue-based reference model.

module tb_mmu_port_arbiter;

   localparam int NP = 3;
   localparam int W  = 32;
   localparam int OW = 2;
   localparam int MO = 4;

   localparam logic [W-1:0] A0 = 32'h0000_0A00;
   localparam logic [W-1:0] A1 = 32'h0000_0100;
   localparam logic [W-1:0] A2 = 32'h0000_0300;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP-1:0]   req_valid, req_ready;
   logic [NP-1:0]   resp_valid, resp_ready;
   logic [NP*W-1:0] req_addr, req_data;
   logic [NP*OW-1:0] req_op;
   logic [W-1:0]    resp_data;
   logic            mready, mvalid;
   logic [W-1:0]    m_addr, m_data;
   logic [OW-1:0]   m_op;
   logic            mresp_ready, mresp_valid;
   logic [W-1:0]    mresp_data;

   int n_cmp = 0;
   int n_bad = 0;

   int m_last = NP - 1;
   bit m_locked = 1'b0;
   int m_lp = 0;
   int m_q[$];

   int hs_port = -1;
   bit hs_pop = 1'b0;
   int cyc = 0;
   int mmu_q[$];
   int rsp_n = 0;
   bit pending[NP];

   mmu_port_arbiter #(
      .NUM_PORTS(NP), .WORD_WIDTH(W),
      .OP_WIDTH(OW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .req_valid_in(req_valid),
      .req_ready_out(req_ready),
      .req_address_in(req_addr),
      .req_operation_in(req_op),
      .req_data_in(req_data),
      .resp_valid_out(resp_valid),
      .resp_ready_in(resp_ready),
      .resp_data_out(resp_data),
      .mmu_request_ready_in(mready),
      .mmu_request_valid_out(mvalid),
      .mmu_request_address_out(m_addr),
      .mmu_request_operation_out(m_op),
      .mmu_request_data_out(m_data),
      .mmu_response_ready_out(mresp_ready),
      .mmu_response_valid_in(mresp_valid),
      .mmu_response_data_in(mresp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   // Who must win this cycle, from the model's own bookkeeping
   function automatic int mgrant();
      if (m_locked) return m_lp;
      for (int k = 1; k <= NP; k++) begin
         if (bit'(req_valid >> ((m_last + k) % NP)))
            return (m_last + k) % NP;
      end
      return -1;
   endfunction

   task automatic model_step();
      int g;
      bit ev;
      hs_port = -1;
      hs_pop = 1'b0;
      if (rst) begin
         m_last = NP - 1;
         m_locked = 1'b0;
         m_q.delete();
         return;
      end
      g = mgrant();
      ev = (g >= 0) && bit'(req_valid >> g) && (m_q.size() < MO);
      hs_pop = (m_q.size() > 0) && mresp_valid
               && bit'(resp_ready >> m_q[0]);
      if (ev && mready) begin
         hs_port = g;
         m_last = g;
         m_locked = 1'b0;
      end else if (ev) begin
         m_locked = 1'b1;
         m_lp = g;
      end
      if (hs_pop) void'(m_q.pop_front());
      if (hs_port >= 0) m_q.push_back(g);
   endtask

   task automatic compare();
      int g, hd;
      bit full, ne, ev;
      logic [NP-1:0] er;
      if (rst) begin
         chk("rst_mvalid", 64'(mvalid), 64'(0));
         chk("rst_rdy", 64'(req_ready), 64'(0));
         chk("rst_rvalid", 64'(resp_valid), 64'(0));
         chk("rst_mrdy", 64'(mresp_ready), 64'(0));
         chk("rst_addr", 64'(m_addr), 64'(0));
         chk("rst_data", 64'(m_data), 64'(0));
         chk("rst_rdata", 64'(resp_data), 64'(0));
         return;
      end
      g = mgrant();
      full = (m_q.size() == MO);
      ne = (m_q.size() != 0);
      hd = ne ? m_q[0] : 0;
      ev = (g >= 0) && bit'(req_valid >> g) && !full;
      chk("mmu_valid", 64'(mvalid), 64'(ev));
      if (ev) begin
         chk("mmu_addr", 64'(m_addr), 64'(req_addr[g*W +: W]));
         chk("mmu_op", 64'(m_op), 64'(req_op[g*OW +: OW]));
         chk("mmu_data", 64'(m_data), 64'(req_data[g*W +: W]));
      end
      er = '0;
      if (g >= 0 && mready && !full) er = NP'(1) << g;
      if (g >= 0) chk("req_ready", 64'(req_ready), 64'(er));
      else chk("req_ready_1hot", 64'($countones(req_ready) <= 1), 64'(1));
      er = '0;
      if (ne && mresp_valid) er = NP'(1) << hd;
      chk("resp_valid", 64'(resp_valid), 64'(er));
      chk("mresp_ready", 64'(mresp_ready),
          64'(ne && bit'(resp_ready >> hd)));
      chk("resp_data", 64'(resp_data), 64'(mresp_data));
   endtask

   initial forever begin
      @(negedge clk);
      compare();
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
   endtask

   // Bench MMU: in-order responses, each held until taken
   task automatic drive_mmu(input int lat, input bit rnd);
      if (hs_pop) begin
         void'(mmu_q.pop_front());
         rsp_n++;
         mresp_valid = 1'b0;
      end
      if (hs_port >= 0) mmu_q.push_back(cyc + lat - 1);
      if (!mresp_valid && mmu_q.size() > 0 && mmu_q[0] <= cyc
          && (!rnd || $urandom_range(3) != 0))
         mresp_valid = 1'b1;
      mresp_data = 32'hDEAD_0000 + 32'(rsp_n);
   endtask

   task automatic set_port(input int p, input logic [W-1:0] a,
                           input logic [OW-1:0] o,
                           input logic [W-1:0] d);
      req_addr[p*W +: W] = a;
      req_op[p*OW +: OW] = o;
      req_data[p*W +: W] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      mresp_valid = 1'b0;
      mready = 1'b0;
      resp_ready = '0;
      mmu_q.delete();
      for (int p = 0; p < NP; p++) pending[p] = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic drain();
      req_valid = '0;
      resp_ready = '1;
      repeat (8) begin
         tick();
         drive_mmu(2, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '1;
      resp_ready = '1;
      mready = 1'b1;
      mresp_valid = 1'b1;
      mresp_data = 32'h1234_5678;
      req_addr = '0;
      req_op = '0;
      req_data = '0;
      set_port(0, A0, 2'd1, 32'hD000_0000);
      set_port(1, A1, 2'd2, 32'hD000_0001);
      set_port(2, A2, 2'd3, 32'hD000_0002);
      #1;
      chk("t0_mvalid", 64'(mvalid), 64'(0));
      chk("t0_rdy", 64'(req_ready), 64'(0));
      chk("t0_rvalid", 64'(resp_valid), 64'(0));
      chk("t0_mrdy", 64'(mresp_ready), 64'(0));
      chk("t0_addr", 64'(m_addr), 64'(0));
      chk("t0_rdata", 64'(resp_data), 64'(0));

      // ports 0,1 continuously valid: grants alternate
      do_reset();
      req_valid = 3'b011;
      mready = 1'b1;
      resp_ready = '1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         drive_mmu(2, 1'b0);
         #1;
         if (i < 6) chk("alt_addr", 64'(m_addr), 64'((i % 2) ? A1 : A0));
         if (i == 2) begin
            chk("alt_rv0", 64'(resp_valid), 64'(3'b001));
            chk("alt_rd0", 64'(resp_data), 64'(32'hDEAD_0000));
         end
         if (i == 3) begin
            chk("alt_rv1", 64'(resp_valid), 64'(3'b010));
            chk("alt_rd1", 64'(resp_data), 64'(32'hDEAD_0001));
         end
      end
      drain();

      // stalled port 1 keeps the grant while port 0 waits
      do_reset();
      resp_ready = '1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         drive_mmu(2, 1'b0);
         req_valid = (i < 2) ? 3'b010 : (i < 4) ? 3'b011 : 3'b001;
         mready = (i >= 3);
         #1;
         if (i < 4) chk("lock_addr", 64'(m_addr), 64'(A1));
         if (i == 3) chk("lock_rdy", 64'(req_ready), 64'(3'b010));
         if (i == 4) begin
            chk("lock_next_addr", 64'(m_addr), 64'(A0));
            chk("lock_next_v", 64'(mvalid), 64'(1));
         end
      end
      drain();

      // silent MMU: exactly MO accepted, no full bypass on a pop
      do_reset();
      req_valid = 3'b001;
      mready = 1'b1;
      resp_ready = '1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         mresp_valid = (i == 6);
         mresp_data = 32'hDEAD_BEEF;
         #1;
         if (i < 4) chk("full_acc", 64'(mvalid), 64'(1));
         if (i == 4 || i == 5) chk("full_stall", 64'(mvalid), 64'(0));
         if (i == 6) begin
            chk("full_nobypass", 64'(mvalid), 64'(0));
            chk("full_pop_rdy", 64'(mresp_ready), 64'(1));
         end
         if (i == 7) chk("full_reopen", 64'(mvalid), 64'(1));
      end

      // response held by port 0, then unexpected response on empty FIFO
      do_reset();
      mready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         req_valid = (i == 0) ? 3'b001 : 3'b000;
         mresp_valid = (i >= 1);
         mresp_data = 32'hDEAD_0042;
         resp_ready = (i == 3) ? 3'b001 : (i >= 4) ? 3'b111 : 3'b000;
         #1;
         if (i == 0) chk("hold_acc", 64'(mvalid), 64'(1));
         if (i == 1 || i == 2) begin
            chk("hold_mrdy", 64'(mresp_ready), 64'(0));
            chk("hold_rv", 64'(resp_valid), 64'(3'b001));
         end
         if (i == 3) begin
            chk("hold_deliver", 64'(mresp_ready), 64'(1));
            chk("hold_data", 64'(resp_data), 64'(32'hDEAD_0042));
         end
         if (i >= 4) begin
            chk("empty_mrdy", 64'(mresp_ready), 64'(0));
            chk("empty_rv", 64'(resp_valid), 64'(0));
         end
      end
      mresp_valid = 1'b0;

      // reset with three outstanding requests
      do_reset();
      req_valid = 3'b111;
      mready = 1'b1;
      resp_ready = '1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         rst = (i == 3);
         mresp_valid = (i >= 3);
         #1;
         if (i == 0) chk("rr_a0", 64'(m_addr), 64'(A0));
         if (i == 1) chk("rr_a1", 64'(m_addr), 64'(A1));
         if (i == 2) chk("rr_a2", 64'(m_addr), 64'(A2));
         if (i == 3) begin
            chk("mid_rst_mvalid", 64'(mvalid), 64'(0));
            chk("mid_rst_rdy", 64'(req_ready), 64'(0));
            chk("mid_rst_rv", 64'(resp_valid), 64'(0));
            chk("mid_rst_mrdy", 64'(mresp_ready), 64'(0));
         end
         if (i == 4) begin
            chk("post_rst_empty", 64'(mresp_ready), 64'(0));
            chk("post_rst_p0", 64'(m_addr), 64'(A0));
         end
      end
      mresp_valid = 1'b0;

      // randomized traffic with occasional mid-run resets
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c > 0) tick();
         if (rst) begin
            rst = 1'b0;
            mmu_q.delete();
            mresp_valid = 1'b0;
         end else begin
            drive_mmu(1 + $urandom_range(3), 1'b1);
         end
         if (hs_port >= 0) pending[hs_port] = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (!pending[p] && $urandom_range(2) == 0) begin
               pending[p] = 1'b1;
               set_port(p, $urandom, OW'($urandom_range(3)), $urandom);
            end
            req_valid[p] = pending[p];
            resp_ready[p] = ($urandom_range(3) != 0);
         end
         mready = ($urandom_range(3) != 0);
         if ($urandom_range(700) == 0) rst = 1'b1;
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mmu_port_arbiter.md
# mmu_port_arbiter

Parametrised N-to-1 arbiter that lets several core-side requesters (instruction fetch, data load/store, future prefetch or page-walk ports) share a single MMU request/response port. Requests pass through with round-robin arbitration and grant locking. An in-order tag FIFO routes each MMU response back to the port that issued it. The block sits between the processor core's memory clients and the MMU, replacing the dedicated per-client MMU channels.

## Interface
Parameters:
- NUM_PORTS, 2, number of requester ports (≥2)
- WORD_WIDTH, 32, address/data width
- OP_WIDTH, 2, width of the memory-operation code (carried opaquely)
- MAX_OUTSTANDING, 4, tag FIFO depth = max requests accepted by MMU but not yet responded (power of 2, ≥2)

Ports (port i occupies slice [i*W +: W] of packed buses):
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- req_valid_in  in  NUM_PORTS  per-port request valid
- req_ready_out  out  NUM_PORTS  per-port request ready
- req_address_in  in  NUM_PORTS*WORD_WIDTH  request addresses
- req_operation_in  in  NUM_PORTS*OP_WIDTH  request operations
- req_data_in  in  NUM_PORTS*WORD_WIDTH  store data
- resp_valid_out  out  NUM_PORTS  per-port response valid
- resp_ready_in  in  NUM_PORTS  per-port response ready
- resp_data_out  out  WORD_WIDTH  response data, broadcast to all ports
- mmu_request_ready_in  in  1
- mmu_request_valid_out  out  1
- mmu_request_address_out  out  WORD_WIDTH
- mmu_request_operation_out  out  OP_WIDTH
- mmu_request_data_out  out  WORD_WIDTH
- mmu_response_ready_out  out  1
- mmu_response_valid_in  in  1
- mmu_response_data_in  in  WORD_WIDTH

## Operation
- Every accepted request, including stores, produces exactly one MMU response. The MMU returns responses in request order.
- State: `last_grant` (index), `locked` flag + `locked_port`, tag FIFO (MAX_OUTSTANDING entries of $clog2(NUM_PORTS) bits, read/write pointers, count of $clog2(MAX_OUTSTANDING)+1 bits).
- Grant selection:
  - If `locked`, grant = `locked_port`.
  - Otherwise grant = first i with req_valid_in[i] set, scanning from last_grant+1 upward and wrapping mod NUM_PORTS.
- Request path, combinational:
  - mmu_request_valid_out = any valid granted && FIFO not full.
  - The MMU address/operation/data outputs mux from the granted port.
  - req_ready_out[grant] = mmu_request_ready_in && FIFO not full. All other bits are 0.
- On request handshake (mmu valid && ready):
  - Push grant into the FIFO.
  - last_grant ← grant.
  - locked ← 0.
- If mmu_request_valid_out is high without ready: locked ← 1 and locked_port ← grant. Address/op/data then stay stable until the handshake.
- Response path:
  - head = FIFO read entry.
  - resp_valid_out[head] = mmu_response_valid_in && FIFO not empty. Other bits are 0.
  - mmu_response_ready_out = resp_ready_in[head] && FIFO not empty.
  - Pop on response handshake.
- FIFO full: no new request is accepted, even if a pop occurs in the same cycle (no full bypass).
- FIFO empty: mmu_response_ready_out = 0. An unexpected MMU response stalls and is never dropped.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap mod MAX_OUTSTANDING.
- A requester dropping valid while locked is a protocol violation; behaviour is undefined.

## Timing
- Reset (rst_in high at a rising edge):
  - last_grant ← NUM_PORTS-1, so port 0 wins first.
  - locked ← 0.
  - FIFO emptied.
- While rst_in is high, all outputs are forced to 0: req_ready_out, resp_valid_out, mmu_request_valid_out, mmu_response_ready_out. Data/address outputs are 0.
- Reset mid-operation discards all outstanding tags. The MMU must be reset on the same edge.
- Zero added latency on both paths (combinational pass-through). Throughput is one request and one response per cycle.
- Arbitration and lock state update on the edge following the observed handshake or stall.

## Test plan
- Ports 0 and 1 both valid continuously, MMU always ready, responses returned 2 cycles later -> grants alternate 0,1,0,1… Each response reaches the issuing port with the MMU data unchanged (e.g. 0xDEAD_0000+n).
- Port 1 valid with address 0x100, MMU ready low 3 cycles; port 0 asserts valid in cycle 2 -> grant stays on port 1, mmu_request_address_out = 0x100 throughout, port 0 is served after.
- MAX_OUTSTANDING=4, MMU never responds -> exactly 4 requests accepted, then mmu_request_valid_out = 0. The first response re-enables acceptance on the next cycle, not the same one.
- Response for port 0 arrives while resp_ready_in[0]=0 for 2 cycles -> mmu_response_ready_out = 0 for those cycles, data held, delivered on the third.
- mmu_response_valid_in=1 with the FIFO empty -> mmu_response_ready_out = 0, every resp_valid_out bit 0.
- Reset asserted with 3 outstanding requests -> next cycle FIFO empty, all outputs 0 during reset; after release, port 0 is granted first. Repeat with NUM_PORTS=3.
